// File: rtl/fifo_sync_level.sv
// fifo_sync_level
//   Single-clock FIFO with level-sensitive push/pop, an occupancy count,
//   programmable almost-full/almost-empty thresholds and sticky
//   overflow/underflow flags. Any DEPTH >= 2 is supported.
//
//   Optional build macro: FIFO_SYNC_LEVEL_FWFT_EN
//     defined   -> first-word-fall-through; o_RdData shows the head word.
//     undefined -> o_RdData is a register loaded on each accepted pop.
//
// Ports
//   i_Clock        sole clock, rising edge
//   i_Reset        synchronous active-high reset
//   i_Clear        synchronous flush of pointers, count and error flags
//   i_WrData       write word
//   i_WrEnable     push request (level)
//   i_RdEnable     pop request (level)
//   o_RdData       read word
//   o_CanWrite     not full
//   o_CanRead      not empty
//   o_Count        occupancy, 0..DEPTH
//   o_AlmostFull   count >= ALMOST_FULL_LEVEL
//   o_AlmostEmpty  count <= ALMOST_EMPTY_LEVEL
//   o_Overflow     sticky: push attempted while full
//   o_Underflow    sticky: pop attempted while empty
module fifo_sync_level #(
  parameter int DATA_WIDTH         = 8,
  parameter int DEPTH              = 4,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 1,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_Clear,
  input  logic [DATA_WIDTH-1:0]        i_WrData,
  input  logic                         i_WrEnable,
  input  logic                         i_RdEnable,
  output logic [DATA_WIDTH-1:0]        o_RdData,
  output logic                         o_CanWrite,
  output logic                         o_CanRead,
  output logic [$clog2(DEPTH+1)-1:0]   o_Count,
  output logic                         o_AlmostFull,
  output logic                         o_AlmostEmpty,
  output logic                         o_Overflow,
  output logic                         o_Underflow
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;
  logic                  push_ok;
  logic                  pop_ok;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_CanWrite    = (count != CW'(DEPTH));
  assign o_CanRead     = (count != '0);
  assign o_Count       = count;
  assign o_AlmostFull  = (count >= CW'(ALMOST_FULL_LEVEL));
  assign o_AlmostEmpty = (count <= CW'(ALMOST_EMPTY_LEVEL));
  assign o_Overflow    = overflow;
  assign o_Underflow   = underflow;

  // Acceptance is judged on pre-edge occupancy, so a full FIFO rejects a
  // push even when a pop is accepted in the same cycle (and vice versa).
  assign push_ok = i_WrEnable & o_CanWrite;
  assign pop_ok  = i_RdEnable & o_CanRead;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (i_Clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_next(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);
      if (i_WrEnable && !o_CanWrite) overflow  <= 1'b1;
      if (i_RdEnable && !o_CanRead)  underflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // after a push, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge i_Clock) begin
    if (push_ok && !i_Reset && !i_Clear) mem[wr_ptr] <= i_WrData;
  end

`ifdef FIFO_SYNC_LEVEL_FWFT_EN
  // Head word is always on the output; a pop simply advances rd_ptr.
  assign o_RdData = mem[rd_ptr];
`else
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset)                rd_data_q <= '0;
    else if (!i_Clear && pop_ok) rd_data_q <= mem[rd_ptr];
  end

  assign o_RdData = rd_data_q;
`endif

endmodule

// File: tb/tb_fifo_sync_level.sv
// Bench for fifo_sync_level: two instances (DEPTH=4 defaults, DEPTH=5 with
// different thresholds) share one stimulus stream. A queue-based reference
// model predicts status each cycle; every accepted pop pushes its expected
// word into a per-instance scoreboard queue that a separate monitor drains.
module tb_fifo_sync_level;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wr_data;

  logic [7:0] rd_data   [2];
  logic       can_write [2];
  logic       can_read  [2];
  logic [2:0] count     [2];
  logic       afull     [2];
  logic       aempty    [2];
  logic       ovf       [2];
  logic       unf       [2];

  always #5 clk = ~clk;

  fifo_sync_level #(.DATA_WIDTH(8), .DEPTH(4)) u_d4 (
    .i_Clock(clk), .i_Reset(rst), .i_Clear(clr), .i_WrData(wr_data),
    .i_WrEnable(wr_en), .i_RdEnable(rd_en), .o_RdData(rd_data[0]),
    .o_CanWrite(can_write[0]), .o_CanRead(can_read[0]), .o_Count(count[0]),
    .o_AlmostFull(afull[0]), .o_AlmostEmpty(aempty[0]),
    .o_Overflow(ovf[0]), .o_Underflow(unf[0])
  );

  fifo_sync_level #(.DATA_WIDTH(8), .DEPTH(5), .ALMOST_FULL_LEVEL(3),
                    .ALMOST_EMPTY_LEVEL(2)) u_d5 (
    .i_Clock(clk), .i_Reset(rst), .i_Clear(clr), .i_WrData(wr_data),
    .i_WrEnable(wr_en), .i_RdEnable(rd_en), .o_RdData(rd_data[1]),
    .o_CanWrite(can_write[1]), .o_CanRead(can_read[1]), .o_Count(count[1]),
    .o_AlmostFull(afull[1]), .o_AlmostEmpty(aempty[1]),
    .o_Overflow(ovf[1]), .o_Underflow(unf[1])
  );

  // Reference model: FIFO contents as a plain queue plus sticky flags.
  int         dep [2] = '{4, 5};
  int         afl [2] = '{3, 3};
  int         ael [2] = '{1, 2};
  logic [7:0] mq0[$], mq1[$];   // modelled contents
  logic [7:0] eq0[$], eq1[$];   // scoreboard: expected popped words
  logic       m_ov   [2] = '{1'b0, 1'b0};
  logic       m_un   [2] = '{1'b0, 1'b0};
  logic [7:0] m_last [2] = '{8'h00, 8'h00};

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [7:0] q_front(input int k);
    return (k == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic model_step(input int k);
    int         n;
    logic [7:0] d;
    n = q_size(k);
    if (rst) begin
      if (k == 0) mq0.delete(); else mq1.delete();
      m_ov[k] = 1'b0; m_un[k] = 1'b0; m_last[k] = 8'h00;
    end else if (clr) begin
      if (k == 0) mq0.delete(); else mq1.delete();
      m_ov[k] = 1'b0; m_un[k] = 1'b0;
    end else begin
      if (wr_en && n == dep[k]) m_ov[k] = 1'b1;
      if (rd_en && n == 0)      m_un[k] = 1'b1;
      if (rd_en && n != 0) begin
        if (k == 0) begin d = mq0.pop_front(); eq0.push_back(d); end
        else        begin d = mq1.pop_front(); eq1.push_back(d); end
        m_last[k] = d;
      end
      if (wr_en && n != dep[k]) begin
        if (k == 0) mq0.push_back(wr_data); else mq1.push_back(wr_data);
      end
    end
  endtask

  task automatic check_status(input int k);
    string p;
    int    n;
    p = $sformatf("d%0d", dep[k]);
    n = q_size(k);
    check({p, ".count"},     count[k],     n);
    check({p, ".can_write"}, can_write[k], n != dep[k]);
    check({p, ".can_read"},  can_read[k],  n != 0);
    check({p, ".almost_full"},  afull[k],  n >= afl[k]);
    check({p, ".almost_empty"}, aempty[k], n <= ael[k]);
    check({p, ".overflow"},  ovf[k], m_ov[k]);
    check({p, ".underflow"}, unf[k], m_un[k]);
`ifdef FIFO_SYNC_LEVEL_FWFT_EN
    if (n != 0) check({p, ".head_word"}, rd_data[k], q_front(k));
`else
    check({p, ".rd_data_hold"}, rd_data[k], m_last[k]);
`endif
  endtask

  // Monitor: whenever a DUT accepts a pop, compare its read word against
  // the scoreboard entry queued when the stimulus was issued.
  task automatic mon_cmp(input int k);
    logic [7:0] d;
    if ((k == 0 ? eq0.size() : eq1.size()) == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL d%0d.pop_data: got 0x%0h, expected no pop at %0t", dep[k], rd_data[k], $time);
    end else begin
      d = (k == 0) ? eq0.pop_front() : eq1.pop_front();
      check($sformatf("d%0d.pop_data", dep[k]), rd_data[k], d);
    end
  endtask

  always @(posedge clk) begin
    logic f0, f1;
    f0 = !rst && !clr && rd_en && (can_read[0] === 1'b1);
    f1 = !rst && !clr && rd_en && (can_read[1] === 1'b1);
`ifndef FIFO_SYNC_LEVEL_FWFT_EN
    #1;  // registered read: word appears just after the pop edge
`endif
    if (f0) mon_cmp(0);
    if (f1) mon_cmp(1);
  end

  task automatic cycle(input logic r, input logic c, input logic w,
                       input logic rd, input logic [7:0] d);
    @(negedge clk);
    rst = r; clr = c; wr_en = w; rd_en = rd; wr_data = d;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #2;
    check_status(0);
    check_status(1);
  endtask

  initial begin
    int wb, rb;
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;

    // Reset, then three pushes and three pops.
    cycle(1, 0, 0, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'h11);
    cycle(0, 0, 1, 0, 8'h22);
    cycle(0, 0, 1, 0, 8'h33);
    check("d4.count_after_3_pushes", count[0], 3);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 8'h00);

    // Fill DEPTH=4, then push+pop while full: pop wins, push dropped.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 8'hC0 + 8'(i));
    cycle(0, 0, 1, 1, 8'hAA);
    check("d4.overflow_on_full_pushpop", ovf[0], 1'b1);

    // Drain past empty, flush, then push+pop into an empty FIFO.
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 8'h00);
    cycle(0, 1, 0, 0, 8'h00);
    cycle(0, 0, 1, 1, 8'h5A);
    check("d4.count_after_empty_pushpop", count[0], 1);
    cycle(0, 0, 0, 1, 8'h00);

    // Two-word prefill then 12 simultaneous push/pop across pointer wrap.
    cycle(0, 0, 1, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'h01);
    for (int i = 2; i < 14; i++) cycle(0, 0, 1, 1, 8'(i));
    check("d5.count_steady_state", count[1], 2);
    cycle(0, 0, 0, 1, 8'h00);
    cycle(0, 0, 0, 1, 8'h00);

    // Clear with push high, then reset mid-stream.
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 8'h40 + 8'(i));
    cycle(0, 1, 1, 0, 8'hEE);
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, 8'h50 + 8'(i));
    cycle(1, 0, 1, 1, 8'h99);

    // Randomised traffic, alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 2000; i++) begin
      wb = ((i / 150) % 2 == 0) ? 75 : 30;
      rb = 100 - wb;
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 119) == 0,
            $urandom_range(0, 99) < wb, $urandom_range(0, 99) < rb,
            8'($urandom));
    end

    @(negedge clk);
    check("d4.scoreboard_drained", eq0.size(), 0);
    check("d5.scoreboard_drained", eq1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
